// File: rtl/subu_arbiter.sv
// subu_arbiter: round-robin sharing of one unsigned subtractor among NREQ
// requesters. One operation is accepted per cycle over valid/ready, and the
// result lands in a single output register tagged with requester id and borrow.
module subu_arbiter #(
  parameter int NREQ = 4,
  parameter int L1   = 8,
  parameter int L2   = 8,
  parameter int IDW  = 2
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic [NREQ-1:0]                   req_valid,
  input  logic [NREQ*L1-1:0]                req_in1,
  input  logic [NREQ*L2-1:0]                req_in2,
  output logic [NREQ-1:0]                   req_ready,
  output logic                              out_valid,
  input  logic                              out_ready,
  output logic [((L1 > L2) ? L1 : L2):0]    out_data,
  output logic                              out_borrow,
  output logic [IDW-1:0]                    out_id,
  output logic [15:0]                       op_count
);

  localparam int W = (L1 > L2) ? L1 : L2;

  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

  state_t         state;
  logic [IDW-1:0] ptr;
  logic [IDW-1:0] gnt_idx;
  logic           gnt_vld;
  logic           can_accept;
  logic [L1-1:0]  sel1;
  logic [L2-1:0]  sel2;
  logic [W:0]     ext1;
  logic [W:0]     ext2;
  logic [W:0]     diff;

  assign out_valid  = (state == FULL);
  // Gating with rst_n keeps every grant low while reset is held.
  assign can_accept = rst_n & (~out_valid | out_ready);

  // Round-robin search: first pending request at or after ptr, wrapping.
  always_comb begin
    gnt_vld = 1'b0;
    gnt_idx = '0;
    for (int k = 0; k < NREQ; k++) begin
      int idx;
      idx = int'(ptr) + k;
      if (idx >= NREQ) idx = idx - NREQ;
      if (!gnt_vld && can_accept && req_valid[idx]) begin
        gnt_vld = 1'b1;
        gnt_idx = IDW'(idx);
      end
    end
  end

  assign req_ready = gnt_vld ? (NREQ'(1) << gnt_idx) : '0;

  // Operand mux into the single shared subtractor; W+1 bits carry the borrow.
  always_comb begin
    sel1 = req_in1[gnt_idx*L1 +: L1];
    sel2 = req_in2[gnt_idx*L2 +: L2];
    ext1 = '0;
    ext2 = '0;
    ext1[L1-1:0] = sel1;
    ext2[L2-1:0] = sel2;
    diff = ext1 - ext2;
  end

  // Output register FSM: a grant always loads; an accepted drain with no
  // grant empties; otherwise the result is held frozen.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= EMPTY;
      out_data   <= '0;
      out_borrow <= 1'b0;
      out_id     <= '0;
    end else begin
      case (state)
        EMPTY: begin
          if (gnt_vld) begin
            state      <= FULL;
            out_data   <= diff;
            out_borrow <= diff[W];
            out_id     <= gnt_idx;
          end
        end
        FULL: begin
          if (gnt_vld) begin
            out_data   <= diff;
            out_borrow <= diff[W];
            out_id     <= gnt_idx;
          end else if (out_ready) begin
            state <= EMPTY;
          end
        end
        default: state <= EMPTY;
      endcase
    end
  end

  // Pointer moves to the slot after the winner so it gets lowest priority next.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr <= '0;
    end else if (gnt_vld) begin
      if (gnt_idx == IDW'(NREQ - 1)) ptr <= '0;
      else                           ptr <= gnt_idx + 1'b1;
    end
  end

  // Completed-transfer counter, saturating at all ones.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_count <= '0;
    end else if (out_valid && out_ready && (op_count != 16'hFFFF)) begin
      op_count <= op_count + 16'd1;
    end
  end

endmodule

// File: tb/tb_subu_arbiter.sv
// Bench for subu_arbiter: directed table, hand-written multi-cycle corners,
// and a randomized run against a spec-level reference model.
module tb_subu_arbiter;

  logic        clk;
  logic        rst_n;
  logic [3:0]  req_valid;
  logic [31:0] req_in1;
  logic [31:0] req_in2;
  logic [3:0]  req_ready;
  logic        out_valid;
  logic        out_ready;
  logic [8:0]  out_data;
  logic        out_borrow;
  logic [1:0]  out_id;
  logic [15:0] op_count;

  // Second instance with a narrower subtrahend.
  logic [3:0]  b_valid;
  logic [31:0] b_in1;
  logic [15:0] b_in2;
  logic [3:0]  b_ready;
  logic        b_ovalid;
  logic        b_ordy;
  logic [8:0]  b_data;
  logic        b_borrow;
  logic [1:0]  b_id;
  logic [15:0] b_cnt;

  int errors = 0;
  int checks = 0;

  subu_arbiter #(.NREQ(4), .L1(8), .L2(8), .IDW(2)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_in1(req_in1),
    .req_in2(req_in2), .req_ready(req_ready), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .out_borrow(out_borrow),
    .out_id(out_id), .op_count(op_count)
  );

  subu_arbiter #(.NREQ(4), .L1(8), .L2(4), .IDW(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .req_valid(b_valid), .req_in1(b_in1),
    .req_in2(b_in2), .req_ready(b_ready), .out_valid(b_ovalid),
    .out_ready(b_ordy), .out_data(b_data), .out_borrow(b_borrow),
    .out_id(b_id), .op_count(b_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model state (spec-level: rotate, pick lowest, plain arithmetic).
  int m_valid, m_data, m_borrow, m_id, m_cnt, m_ptr;

  function automatic int model_grant(input logic [3:0] v, input int ptr);
    logic [7:0] dbl;
    dbl = {v, v} >> ptr;
    for (int j = 0; j < 4; j++)
      if (dbl[j]) return (ptr + j) % 4;
    return -1;
  endfunction

  task automatic do_reset();
    req_valid = '0; req_in1 = '0; req_in2 = '0; out_ready = 1'b0;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    m_valid = 0; m_data = 0; m_borrow = 0; m_id = 0; m_cnt = 0; m_ptr = 0;
  endtask

  // One randomized cycle compared against the model.
  task automatic rand_cycle();
    int g, a, b, d;
    logic [3:0] exp_rdy;
    req_valid = 4'($urandom);
    req_in1   = $urandom;
    req_in2   = $urandom;
    out_ready = ($urandom_range(0, 3) != 0);
    @(negedge clk);
    g = -1;
    if (m_valid == 0 || out_ready) g = model_grant(req_valid, m_ptr);
    exp_rdy = (g >= 0) ? 4'(1 << g) : 4'b0;
    chk("rnd_ready", 32'(req_ready), 32'(exp_rdy));
    @(posedge clk);
    if (m_valid != 0 && out_ready && m_cnt < 65535) m_cnt++;
    if (g >= 0) begin
      a = int'(req_in1[g*8 +: 8]);
      b = int'(req_in2[g*8 +: 8]);
      d = a - b;
      if (d < 0) d += 512;
      m_valid = 1; m_data = d; m_borrow = (a < b) ? 1 : 0; m_id = g;
      m_ptr = (g + 1) % 4;
    end else if (out_ready) begin
      m_valid = 0;
    end
    #1;
    chk("rnd_valid", 32'(out_valid), 32'(m_valid));
    chk("rnd_cnt", 32'(op_count), 32'(m_cnt));
    if (m_valid != 0) begin
      chk("rnd_data", 32'(out_data), 32'(m_data));
      chk("rnd_borrow", 32'(out_borrow), 32'(m_borrow));
      chk("rnd_id", 32'(out_id), 32'(m_id));
    end
  endtask

  typedef struct packed {
    logic [3:0] v;
    logic [7:0] a;
    logic [7:0] b;
    logic [3:0] rdy;
    logic [8:0] d;
    logic       bo;
    logic [1:0] id;
  } vec_t;

  vec_t tbl [6];
  logic [8:0] held_d;

  initial begin
    b_valid = '0; b_in1 = '0; b_in2 = '0; b_ordy = 1'b1;

    // Reset state.
    req_valid = '0; req_in1 = '0; req_in2 = '0; out_ready = 1'b0;
    rst_n = 1'b0;
    #2;
    chk("rst_valid", 32'(out_valid), 0);
    chk("rst_data", 32'(out_data), 0);
    chk("rst_cnt", 32'(op_count), 0);
    chk("rst_id", 32'(out_id), 0);
    do_reset();

    // Directed table; same operands presented on every requester per row.
    tbl[0] = '{4'b0001, 8'd200, 8'd55,  4'b0001, 9'h091, 1'b0, 2'd0};
    tbl[1] = '{4'b0100, 8'd5,   8'd10,  4'b0100, 9'h1FB, 1'b1, 2'd2};
    tbl[2] = '{4'b0001, 8'd0,   8'd255, 4'b0001, 9'h101, 1'b1, 2'd0};
    tbl[3] = '{4'b1001, 8'd255, 8'd0,   4'b1000, 9'h0FF, 1'b0, 2'd3};
    tbl[4] = '{4'b1001, 8'd7,   8'd7,   4'b0001, 9'h000, 1'b0, 2'd0};
    tbl[5] = '{4'b0110, 8'd100, 8'd101, 4'b0010, 9'h1FF, 1'b1, 2'd1};
    for (int i = 0; i < 6; i++) begin
      req_valid = tbl[i].v; req_in1 = {4{tbl[i].a}}; req_in2 = {4{tbl[i].b}};
      out_ready = 1'b1;
      @(negedge clk);
      chk("tbl_ready", 32'(req_ready), 32'(tbl[i].rdy));
      @(posedge clk); #1;
      chk("tbl_valid", 32'(out_valid), 1);
      chk("tbl_data", 32'(out_data), 32'(tbl[i].d));
      chk("tbl_borrow", 32'(out_borrow), 32'(tbl[i].bo));
      chk("tbl_id", 32'(out_id), 32'(tbl[i].id));
      chk("tbl_cnt", 32'(op_count), i);
    end

    // Round robin with all requesters pending: 0,1,2,3,0,1, no bubbles.
    do_reset();
    req_valid = 4'b1111;
    req_in1 = {8'd40, 8'd30, 8'd20, 8'd10};
    req_in2 = {8'd1, 8'd2, 8'd3, 8'd4};
    out_ready = 1'b1;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      chk("rr_ready", 32'(req_ready), 32'(1 << (k % 4)));
      @(posedge clk); #1;
      chk("rr_valid", 32'(out_valid), 1);
      chk("rr_id", 32'(out_id), k % 4);
      chk("rr_cnt", 32'(op_count), k);
    end
    chk("rr_last_data", 32'(out_data), 32'h011);

    // Backpressure: result frozen, no grants; release grants index 2.
    held_d = out_data;
    out_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("bp_ready", 32'(req_ready), 0);
      @(posedge clk); #1;
      chk("bp_valid", 32'(out_valid), 1);
      chk("bp_data", 32'(out_data), 32'(held_d));
      chk("bp_id", 32'(out_id), 1);
      chk("bp_cnt", 32'(op_count), 5);
    end
    out_ready = 1'b1;
    @(negedge clk);
    chk("rel_ready", 32'(req_ready), 32'b0100);
    @(posedge clk); #1;
    chk("rel_valid", 32'(out_valid), 1);
    chk("rel_id", 32'(out_id), 2);
    chk("rel_data", 32'(out_data), 32'h01C);
    chk("rel_cnt", 32'(op_count), 6);

    // Narrow subtrahend instance.
    req_valid = '0;
    b_valid = 4'b0001; b_in1 = 32'd0; b_in2 = 16'd15;
    @(posedge clk); #1;
    chk("n_data0", 32'(b_data), 32'h1F1);
    chk("n_borrow0", 32'(b_borrow), 1);
    b_in1 = 32'd255; b_in2 = 16'd0;
    @(posedge clk); #1;
    chk("n_data1", 32'(b_data), 32'h0FF);
    chk("n_borrow1", 32'(b_borrow), 0);
    b_valid = '0;

    // Asynchronous reset mid-cycle with a result held and op_count=3.
    do_reset();
    req_valid = 4'b1111; out_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(posedge clk); #1;
    end
    chk("pre_rst_cnt", 32'(op_count), 3);
    chk("pre_rst_valid", 32'(out_valid), 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_valid", 32'(out_valid), 0);
    chk("arst_cnt", 32'(op_count), 0);
    chk("arst_ready", 32'(req_ready), 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_ready", 32'(req_ready), 32'b0001);
    @(posedge clk); #1;
    chk("post_rst_id", 32'(out_id), 0);

    // Randomized run against the reference model.
    do_reset();
    for (int n = 0; n < 400; n++) rand_cycle();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
